// File: rtl/restador_q22_pipe.sv
// restador_q22_pipe: two-stage sign-magnitude Q2.2 subtractor (c = a - b) with valid/ready on both sides.
// Optional macro RESTADOR_ADDSUB_EN adds an 'op' port selecting add (0) or subtract (1).
`default_nettype none

module restador_q22_pipe #(
    parameter int MAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [MAG_W:0]   a,
    input  logic [MAG_W:0]   b,
`ifdef RESTADOR_ADDSUB_EN
    input  logic             op,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [MAG_W+1:0] c
);

    logic             op_sub;
    logic             en1;
    logic             en2;

    logic             sa_d;
    logic             sb_d;
    logic [MAG_W-1:0] ma_d;
    logic [MAG_W-1:0] mb_d;

    logic             s1_valid_q;
    logic             sa_q;
    logic             sb_q;
    logic [MAG_W-1:0] ma_q;
    logic [MAG_W-1:0] mb_q;
    logic             same_q;
    logic             age_q;

    logic [MAG_W:0]   mag_d;
    logic             sign_d;
    logic             out_valid_q;
    logic [MAG_W+1:0] c_q;

`ifdef RESTADOR_ADDSUB_EN
    assign op_sub = op;
`else
    assign op_sub = 1'b1;
`endif

    assign en2      = !out_valid_q || out_ready;
    assign en1      = !s1_valid_q || en2;
    assign in_ready = en1;

    // Input -0 folds to +0 before b's sign is flipped for subtraction.
    always_comb begin
        ma_d = a[MAG_W-1:0];
        mb_d = b[MAG_W-1:0];
        sa_d = a[MAG_W] & (|ma_d);
        sb_d = (b[MAG_W] & (|mb_d)) ^ op_sub;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            sa_q       <= 1'b0;
            sb_q       <= 1'b0;
            ma_q       <= '0;
            mb_q       <= '0;
            same_q     <= 1'b0;
            age_q      <= 1'b0;
        end else if (en1) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                sa_q   <= sa_d;
                sb_q   <= sb_d;
                ma_q   <= ma_d;
                mb_q   <= mb_d;
                same_q <= (sa_d == sb_d);
                age_q  <= (ma_d >= mb_d);
            end
        end
    end

    always_comb begin
        if (same_q) begin
            mag_d  = {1'b0, ma_q} + {1'b0, mb_q};
            sign_d = sa_q;
        end else if (age_q) begin
            mag_d  = {1'b0, ma_q - mb_q};
            sign_d = sa_q;
        end else begin
            mag_d  = {1'b0, mb_q - ma_q};
            sign_d = sb_q;
        end
        if (mag_d == '0) begin
            sign_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            c_q         <= '0;
        end else if (en2) begin
            out_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                c_q <= {sign_d, mag_d};
            end
        end
    end

    assign out_valid = out_valid_q;
    assign c         = c_q;

endmodule

`default_nettype wire

// File: tb/tb_restador_q22_pipe.sv
// Directed bench for restador_q22_pipe: reset, streaming vectors, back-pressure and mid-flight reset.
`default_nettype none

module tb_restador_q22_pipe;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [4:0] a;
    logic [4:0] b;
    logic       out_valid;
    logic       out_ready;
    logic [5:0] c;
`ifdef RESTADOR_ADDSUB_EN
    logic       op;
`endif

    int total = 0;
    int bad   = 0;

    restador_q22_pipe #(.MAG_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
`ifdef RESTADOR_ADDSUB_EN
        .op        (op),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .c         (c)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    localparam int NV = 9;
    logic [4:0] va [NV] = '{5'b0_0110, 5'b0_0010, 5'b0_1111, 5'b1_1111, 5'b1_0101,
                            5'b1_0000, 5'b1_0011, 5'b0_0000, 5'b1_0000};
    logic [4:0] vb [NV] = '{5'b0_0010, 5'b0_0110, 5'b1_1111, 5'b0_1111, 5'b1_0101,
                            5'b0_0000, 5'b1_0101, 5'b0_0011, 5'b1_0000};
    logic [5:0] vc [NV] = '{6'b00_0100, 6'b10_0100, 6'b01_1110, 6'b11_1110, 6'b00_0000,
                            6'b00_0000, 6'b00_0010, 6'b10_0011, 6'b00_0000};

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        out_ready = 1'b1;
`ifdef RESTADOR_ADDSUB_EN
        op        = 1'b1;
`endif
        tick();
        tick();
        chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_c", {26'd0, c}, 32'd0);
        chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
        rst = 1'b0;
        tick();

        // Single transaction latency: visible exactly two edges after acceptance.
        a = 5'b0_0110; b = 5'b0_0010; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("lat_not_yet", {31'd0, out_valid}, 32'd0);
        tick();
        chk("lat_out_valid", {31'd0, out_valid}, 32'd1);
        chk("lat_c", {26'd0, c}, 32'b00_0100);
        tick();
        chk("lat_drained", {31'd0, out_valid}, 32'd0);

        // Back-to-back stream, one result per cycle.
        for (int i = 0; i <= NV; i++) begin
            if (i < NV) begin
                a = va[i]; b = vb[i]; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            tick();
            if (i >= 1) begin
                chk($sformatf("stream_valid_%0d", i - 1), {31'd0, out_valid}, 32'd1);
                chk($sformatf("stream_c_%0d", i - 1), {26'd0, c}, {26'd0, vc[i-1]});
            end
        end
        in_valid = 1'b0;
        tick();
        chk("stream_drained", {31'd0, out_valid}, 32'd0);

        // Back-pressure with three queued inputs.
        out_ready = 1'b0;
        a = 5'b0_0001; b = 5'b0_0000; in_valid = 1'b1;
        #1;
        chk("bp_ready_0", {31'd0, in_ready}, 32'd1);
        tick();
        a = 5'b0_0010;
        #1;
        chk("bp_ready_1", {31'd0, in_ready}, 32'd1);
        tick();
        a = 5'b0_0011;
        #1;
        chk("bp_ready_full", {31'd0, in_ready}, 32'd0);
        chk("bp_hold_valid", {31'd0, out_valid}, 32'd1);
        chk("bp_hold_c", {26'd0, c}, 32'b00_0001);
        tick();
        chk("bp_hold_c2", {26'd0, c}, 32'b00_0001);
        chk("bp_ready_full2", {31'd0, in_ready}, 32'd0);
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        chk("bp_c_second", {26'd0, c}, 32'b00_0010);
        chk("bp_valid_second", {31'd0, out_valid}, 32'd1);
        tick();
        chk("bp_c_third", {26'd0, c}, 32'b00_0011);
        chk("bp_valid_third", {31'd0, out_valid}, 32'd1);
        tick();
        chk("bp_drained", {31'd0, out_valid}, 32'd0);

        // Asynchronous reset with two results in flight.
        out_ready = 1'b0;
        a = 5'b0_0101; b = 5'b0_0001; in_valid = 1'b1;
        tick();
        a = 5'b0_0111;
        tick();
        in_valid = 1'b0;
        chk("rstmid_pre_valid", {31'd0, out_valid}, 32'd1);
        chk("rstmid_pre_c", {26'd0, c}, 32'b00_0100);
        rst = 1'b1;
        #1;
        chk("rstmid_valid", {31'd0, out_valid}, 32'd0);
        chk("rstmid_c", {26'd0, c}, 32'd0);
        chk("rstmid_ready", {31'd0, in_ready}, 32'd1);
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("rstmid_no_stale_%0d", k), {31'd0, out_valid}, 32'd0);
        end
        chk("rstmid_ready_after", {31'd0, in_ready}, 32'd1);

`ifdef RESTADOR_ADDSUB_EN
        op = 1'b0; a = 5'b0_0110; b = 5'b0_0010; in_valid = 1'b1;
        tick();
        op = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("addsub_add", {26'd0, c}, 32'b00_1000);
        tick();
        chk("addsub_sub", {26'd0, c}, 32'b00_0100);
        tick();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
